tournament_chooser: RTL and testbench
=====================================

// Module: tournament_chooser
// PURPOSE
//  Stage directly downstream of the local and global branch predictors.
//  Picks the final Taken prediction with a per-PC 2-bit chooser table.
//  Tracks in-flight predictions in order. Trains the chooser when execute resolves a branch.
//  Flags a mispredict to fetch.
// PARAMETERS
//  IDX_BITS    10  chooser index width; the index is PC[IDX_BITS+1:2], so the table has 2^IDX_BITS entries
//  FIFO_DEPTH  4   in-flight prediction slots; must be a power of 2 and >=2
// PORTS
//  CLK             in   1   clock; all state updates on posedge
//  RESET           in   1   asynchronous, active-low reset
//  Pred_valid      in   1   a branch was fetched this cycle; Local_taken and Global_taken are valid
//  Pred_addr       in   32  PC of that branch
//  Local_taken     in   1   local predictor output
//  Global_taken    in   1   global predictor output
//  Taken           out  1   final prediction (combinational)
//  Resolve_valid   in   1   oldest in-flight branch resolved this cycle
//  Resolve_taken   in   1   actual outcome of that branch
//  Flush           in   1   squash all in-flight entries
//  Mispredict      out  1   registered; 1 for one cycle after a resolve whose outcome != stored final prediction
//  Fifo_full       out  1   in-flight count == FIFO_DEPTH
//  Overflow        out  1   sticky; set when a push is dropped, cleared only by RESET
// BEHAVIOUR
//  Reset (RESET=0, async): all chooser entries = 2'b01; FIFO empty; Mispredict=0; Overflow=0.
//  Reset mid-operation discards all in-flight entries.
//  Chooser selection: MSB=1 selects Global_taken; MSB=0 selects Local_taken.
//  Taken is 0 when Pred_valid=0.
//  Predict: on Pred_valid, push {idx, Local_taken, Global_taken, Taken} into the FIFO at the clock edge.
//  Resolve: on Resolve_valid with FIFO non-empty, pop the head.
//   - If stored local != stored global: increment the chooser (saturate at 11) if global was correct,
//     else decrement (saturate at 00).
//   - If local == global: chooser unchanged.
//   - Mispredict <= (stored final != Resolve_taken); otherwise Mispredict <= 0.
//  Read/write collision: a same-cycle read of an index being updated returns the old value;
//   the new value is visible the next cycle.
//  Resolve on empty FIFO: ignored, no chooser change, Mispredict=0.
//  Push and pop in the same cycle: both occur, including when full; count is unchanged.
//  Push when full without a pop: entry dropped, Overflow <= 1.
//  Flush: the Resolve in the same cycle is processed first (chooser trained, Mispredict computed).
//   Then the FIFO is emptied; a same-cycle push is discarded.
//  Pointers are log2(FIFO_DEPTH) bits and wrap modulo the depth; the count is a separate
//   (log2(FIFO_DEPTH)+1)-bit counter.
//  Latency: Taken has 0 cycles; Mispredict has 1 cycle; a chooser update is visible 1 cycle after resolve.
// CONFIGURATION
//  CHOOSER_STATS_EN defined: two additional outputs.
//   - Stat_pred  out 32: count of accepted pushes.
//   - Stat_mispred out 32: count of Mispredict pulses.
//   Both reset to 0 and wrap at 2^32.
//  CHOOSER_STATS_EN undefined: these ports and their counters do not exist; other behaviour identical.
// STRUCTURE
//  Shared package bp_pkg:
//   - IDX_BITS default.
//   - 2-bit counter constants (SNT=00, WNT=01, WT=10, ST=11).
//   - Typedef of the in-flight entry {idx, local, global, final}.
//   - Saturating inc/dec functions.
//  Sub-module bp_inflight_fifo holds the entry queue, pointers, count, full/empty and flush.
//  The chooser table and training logic stay in the top module.
// TESTING
//  1 After reset, PC 0x00400010, local=0, global=1, Pred_valid=1 -> Taken=0; Fifo_full=0; Mispredict=0.
//  2 Same PC, same inputs, resolve Taken=1 each time, three rounds -> chooser 01->10->11;
//    round 2 Taken=1; round 1 Mispredict=1; rounds 2-3 Mispredict=0.
//  3 local=global=1, resolve Taken=0 -> chooser for that idx unchanged; Mispredict=1 next cycle only.
//  4 4 pushes, no resolve -> Fifo_full=1; 5th push alone -> dropped, Overflow=1;
//    push+pop while full -> count stays 4, FIFO order preserved.
//  5 3 entries, Flush+Resolve_valid same cycle -> head trains chooser; count=0 next cycle;
//    later resolve ignored.
//  6 RESET pulsed low mid-stream with 2 entries -> FIFO empty, Overflow=0, Mispredict=0,
//    chooser back to 01 for the trained idx.

Source files
------------

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared branch-predictor types, counter constants and saturating helpers
package bp_pkg;

    localparam int IDX_BITS_DEFAULT = 10;

    // Wide enough for any PC[IDX_BITS+1:2] slice of a 32-bit address.
    localparam int IDX_FIELD_BITS = 30;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef struct packed {
        logic [IDX_FIELD_BITS-1:0] idx;
        logic                      local_taken;
        logic                      global_taken;
        logic                      final_taken;
    } inflight_entry_t;

    function automatic logic [1:0] sat_inc(input logic [1:0] ctr);
        return (ctr == ST) ? ST : ctr + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] ctr);
        return (ctr == SNT) ? SNT : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// rtl/bp_inflight_fifo.sv - in-order queue of in-flight predictions with flush and sticky overflow
module bp_inflight_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            push,
    input  inflight_entry_t push_data,
    input  logic            pop,
    input  logic            flush,
    output inflight_entry_t head_data,
    output logic            full,
    output logic            push_accept,
    output logic            pop_accept,
    output logic            overflow
);

    localparam int PTR_BITS = $clog2(DEPTH);

    inflight_entry_t       mem [DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr;
    logic [PTR_BITS-1:0]   rd_ptr;
    logic [PTR_BITS:0]     count;
    logic                  empty;
    logic                  push_ok;

    assign empty      = (count == '0);
    assign full       = (count == (PTR_BITS+1)'(DEPTH));
    assign pop_accept = pop && !empty;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign push_ok     = push && (!full || pop_accept);
    assign push_accept = push_ok && !flush;
    assign head_data   = mem[rd_ptr];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push && !push_ok && !flush) begin
                overflow <= 1'b1;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + PTR_BITS'(1);
                end
                if (pop_accept) begin
                    rd_ptr <= rd_ptr + PTR_BITS'(1);
                end
                if (push_ok && !pop_accept) begin
                    count <= count + (PTR_BITS+1)'(1);
                end else if (!push_ok && pop_accept) begin
                    count <= count - (PTR_BITS+1)'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push_accept) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/tournament_chooser.sv
// rtl/tournament_chooser.sv - per-PC local/global chooser with in-order training and mispredict flag
// Optional CHOOSER_STATS_EN adds Stat_pred / Stat_mispred counters.
module tournament_chooser
    import bp_pkg::*;
#(
    parameter int IDX_BITS   = IDX_BITS_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        Pred_valid,
    input  logic [31:0] Pred_addr,
    input  logic        Local_taken,
    input  logic        Global_taken,
    output logic        Taken,
    input  logic        Resolve_valid,
    input  logic        Resolve_taken,
    input  logic        Flush,
    output logic        Mispredict,
    output logic        Fifo_full,
`ifdef CHOOSER_STATS_EN
    output logic [31:0] Stat_pred,
    output logic [31:0] Stat_mispred,
`endif
    output logic        Overflow
);

    localparam int TABLE_SIZE = 2 ** IDX_BITS;

    logic [1:0]          chooser [TABLE_SIZE];
    logic [IDX_BITS-1:0] pred_idx;
    logic [IDX_BITS-1:0] train_idx;
    inflight_entry_t     push_entry;
    inflight_entry_t     head_entry;
    logic                push_accept;
    logic                pop_accept;
    logic                do_train;
    logic [1:0]          train_value;
    logic                mispredict_next;
    logic                unused_bits;

    assign pred_idx  = Pred_addr[IDX_BITS+1:2];
    assign train_idx = head_entry.idx[IDX_BITS-1:0];
    assign Taken     = Pred_valid && (chooser[pred_idx][1] ? Global_taken : Local_taken);

    always_comb begin
        push_entry              = '0;
        push_entry.idx          = IDX_FIELD_BITS'(pred_idx);
        push_entry.local_taken  = Local_taken;
        push_entry.global_taken = Global_taken;
        push_entry.final_taken  = Taken;
    end

    bp_inflight_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK         (CLK),
        .RESET       (RESET),
        .push        (Pred_valid),
        .push_data   (push_entry),
        .pop         (Resolve_valid),
        .flush       (Flush),
        .head_data   (head_entry),
        .full        (Fifo_full),
        .push_accept (push_accept),
        .pop_accept  (pop_accept),
        .overflow    (Overflow)
    );

    // Train only when the two predictors disagreed; agreement says nothing about which is better.
    always_comb begin
        do_train        = pop_accept && (head_entry.local_taken != head_entry.global_taken);
        train_value     = (head_entry.global_taken == Resolve_taken) ? sat_inc(chooser[train_idx])
                                                                     : sat_dec(chooser[train_idx]);
        mispredict_next = pop_accept && (head_entry.final_taken != Resolve_taken);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < TABLE_SIZE; i++) begin
                chooser[i] <= WNT;
            end
        end else if (do_train) begin
            chooser[train_idx] <= train_value;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Mispredict <= 1'b0;
        end else begin
            Mispredict <= mispredict_next;
        end
    end

`ifdef CHOOSER_STATS_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Stat_pred    <= '0;
            Stat_mispred <= '0;
        end else begin
            if (push_accept) begin
                Stat_pred <= Stat_pred + 32'd1;
            end
            if (mispredict_next) begin
                Stat_mispred <= Stat_mispred + 32'd1;
            end
        end
    end
`endif

    assign unused_bits = ^{Pred_addr[31:IDX_BITS+2], Pred_addr[1:0],
                           head_entry.idx[IDX_FIELD_BITS-1:IDX_BITS], push_accept};

endmodule

// File: tb/tb_tournament_chooser.sv
// tb/tb_tournament_chooser.sv - directed self-checking bench for tournament_chooser
module tb_tournament_chooser;

    localparam logic [31:0] PC_A = 32'h0040_0010;
    localparam logic [31:0] PC_B = 32'h0040_0100;
    localparam logic [31:0] PC_C = 32'h0040_0200;
    localparam logic [31:0] PC_D = 32'h0040_0300;
    localparam logic [31:0] PC_E = 32'h0040_0400;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        Pred_valid;
    logic [31:0] Pred_addr;
    logic        Local_taken;
    logic        Global_taken;
    logic        Taken;
    logic        Resolve_valid;
    logic        Resolve_taken;
    logic        Flush;
    logic        Mispredict;
    logic        Fifo_full;
    logic        Overflow;
`ifdef CHOOSER_STATS_EN
    logic [31:0] Stat_pred;
    logic [31:0] Stat_mispred;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    tournament_chooser dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .Pred_valid    (Pred_valid),
        .Pred_addr     (Pred_addr),
        .Local_taken   (Local_taken),
        .Global_taken  (Global_taken),
        .Taken         (Taken),
        .Resolve_valid (Resolve_valid),
        .Resolve_taken (Resolve_taken),
        .Flush         (Flush),
        .Mispredict    (Mispredict),
        .Fifo_full     (Fifo_full),
`ifdef CHOOSER_STATS_EN
        .Stat_pred     (Stat_pred),
        .Stat_mispred  (Stat_mispred),
`endif
        .Overflow      (Overflow)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic pv, input logic [31:0] addr, input logic lt, input logic gt,
                          input logic rv, input logic rt, input logic fl);
        Pred_valid    = pv;
        Pred_addr     = addr;
        Local_taken   = lt;
        Global_taken  = gt;
        Resolve_valid = rv;
        Resolve_taken = rt;
        Flush         = fl;
    endtask

    task automatic idle();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Combinational look at the chooser through Taken; Pred_valid drops before the edge so nothing is pushed.
    task automatic probe(input logic [31:0] addr, input logic lt, input logic gt,
                         input logic exp, input string tag);
        Pred_valid   = 1'b1;
        Pred_addr    = addr;
        Local_taken  = lt;
        Global_taken = gt;
        #1;
        check(tag, {31'b0, Taken}, {31'b0, exp});
        Pred_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] fin_pat;
        logic [3:0] misp_pat;
        fin_pat  = 4'b1101;
        misp_pat = 4'b0110;

        RESET = 1'b0;
        idle();
        @(negedge CLK);
        @(negedge CLK);
        check("rst_misp", {31'b0, Mispredict}, 32'd0);
        check("rst_full", {31'b0, Fifo_full}, 32'd0);
        check("rst_ovf", {31'b0, Overflow}, 32'd0);
        RESET = 1'b1;
        tick();

        // Test 1: chooser 01 picks local
        set_in(1'b1, PC_A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("t1_taken", {31'b0, Taken}, 32'd0);
        tick();
        check("t1_full", {31'b0, Fifo_full}, 32'd0);
        check("t1_misp", {31'b0, Mispredict}, 32'd0);

        // Test 2: three training rounds, 01 -> 10 -> 11 (saturate)
        set_in(1'b0, PC_A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        #1 check("t2_gated", {31'b0, Taken}, 32'd0);
        tick();
        check("t2_r1_misp", {31'b0, Mispredict}, 32'd1);
        for (int r = 2; r <= 3; r++) begin
            set_in(1'b1, PC_A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            #1 check($sformatf("t2_r%0d_taken", r), {31'b0, Taken}, 32'd1);
            tick();
            set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            tick();
            check($sformatf("t2_r%0d_misp", r), {31'b0, Mispredict}, 32'd0);
        end
        idle();
        probe(PC_A, 1'b1, 1'b0, 1'b0, "t2_sat");

        // Read/write collision: old value during the training cycle, new value after
        set_in(1'b1, PC_B, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check("coll_push", {31'b0, Taken}, 32'd1);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        probe(PC_B, 1'b1, 1'b0, 1'b1, "coll_old");
        tick();
        idle();
        check("coll_misp", {31'b0, Mispredict}, 32'd1);
        probe(PC_B, 1'b1, 1'b0, 1'b0, "coll_new");

        // Test 3: agreeing predictors do not train
        set_in(1'b1, PC_C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("t3_taken", {31'b0, Taken}, 32'd1);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("t3_misp", {31'b0, Mispredict}, 32'd1);
        idle();
        tick();
        check("t3_misp_clr", {31'b0, Mispredict}, 32'd0);
        probe(PC_C, 1'b0, 1'b1, 1'b0, "t3_unchanged");

        // Test 4: fill, overflow, push+pop while full, drain in order
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, PC_D + 32'(4 * i), fin_pat[i], fin_pat[i], 1'b0, 1'b0, 1'b0);
            tick();
            check($sformatf("t4_full_%0d", i), {31'b0, Fifo_full}, (i == 3) ? 32'd1 : 32'd0);
        end
        set_in(1'b1, PC_D + 32'd16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("t4_ovf", {31'b0, Overflow}, 32'd1);
        check("t4_full_drop", {31'b0, Fifo_full}, 32'd1);
        set_in(1'b1, PC_D + 32'd20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("t4_pp_misp", {31'b0, Mispredict}, 32'd1);
        check("t4_pp_full", {31'b0, Fifo_full}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
            check($sformatf("t4_pop%0d_misp", i), {31'b0, Mispredict}, {31'b0, misp_pat[i]});
            check($sformatf("t4_pop%0d_full", i), {31'b0, Fifo_full}, 32'd0);
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check("t4_empty_res", {31'b0, Mispredict}, 32'd0);
        check("t4_ovf_sticky", {31'b0, Overflow}, 32'd1);

        // Test 5: flush with same-cycle resolve and push
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, PC_E, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        set_in(1'b1, PC_E, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        check("t5_misp", {31'b0, Mispredict}, 32'd1);
        check("t5_full", {31'b0, Fifo_full}, 32'd0);
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("t5_ignored", {31'b0, Mispredict}, 32'd0);
        idle();
        probe(PC_E, 1'b0, 1'b1, 1'b1, "t5_trained");

        // Test 6: reset mid-stream
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, PC_A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            #1 check($sformatf("t6_push%0d", i), {31'b0, Taken}, 32'd0);
            tick();
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check("t6_pre_misp", {31'b0, Mispredict}, 32'd1);
        idle();
        RESET = 1'b0;
        #1;
        check("t6_rst_misp", {31'b0, Mispredict}, 32'd0);
        check("t6_rst_ovf", {31'b0, Overflow}, 32'd0);
        check("t6_rst_full", {31'b0, Fifo_full}, 32'd0);
        tick();
        RESET = 1'b1;
        probe(PC_A, 1'b0, 1'b1, 1'b0, "t6_chooser");
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check("t6_empty_res", {31'b0, Mispredict}, 32'd0);
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
